reg_trace_buffer: RTL and testbench



---
 rtl/reg_trace_pkg.sv | 19 +
 rtl/reg_trace_buffer_fifo.sv | 62 ++++++
 rtl/reg_trace_buffer.sv | 135 +++++++++++++
 tb/tb_reg_trace_buffer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_trace_pkg.sv
// Shared definitions for the register-write trace buffer: FSM encodings and
// the packed entry width.
package reg_trace_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RUN  = 2'd1,
        ST_POST = 2'd2,
        ST_HALT = 2'd3
    } trace_state_e;

    localparam int DROP_W = 16;

    // One stored entry is {timestamp, address, data}.
    function automatic int entry_w(input int ts_w, input int addr_w, input int data_w);
        return ts_w + addr_w + data_w;
    endfunction

endpackage

// File: rtl/reg_trace_buffer_fifo.sv
// Circular storage for trace entries. The head is read straight from the
// array, so a pushed entry only becomes visible once the count has updated.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_count   = r_count;
    assign w_do_pop  = i_pop && !o_empty;
    // A push into a full FIFO is accepted only when the head leaves this cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
    end

    // Empty reads as zero so stale array contents never reach the outputs.
    assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/reg_trace_buffer.sv
// Register-write trace buffer: filters register-file writes, timestamps them
// into a FIFO, and freezes capture a programmable number of writes after a trigger.
module reg_trace_buffer
    import reg_trace_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16,
    parameter int POST_N = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [(1<<ADDR_W)-1:0]   filt_mask,
    input  logic                     arm,
    input  logic                     flush,
    input  logic                     trig_en,
    input  logic [ADDR_W-1:0]        trig_addr,
    input  logic [DATA_W-1:0]        trig_val,
    input  logic [DATA_W-1:0]        trig_mask,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TS_W-1:0]          out_ts,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DROP_W-1:0]        drop_cnt,
    output logic [1:0]               state
);

    localparam int ENTRY_W = entry_w(TS_W, ADDR_W, DATA_W);
    localparam int PC_W    = $clog2(DEPTH + 1);
    localparam logic [PC_W-1:0] POST_LD = PC_W'(POST_N);

    logic [TS_W-1:0]    r_ts;
    trace_state_e       r_state;
    logic [PC_W-1:0]    r_post_cnt;
    logic [DROP_W-1:0]  r_drop_cnt;

    logic               w_capturing;
    logic               w_capture;
    logic               w_trigger;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_drop;
    logic [ENTRY_W-1:0] w_wr_entry;
    logic [ENTRY_W-1:0] w_rd_entry;

    assign w_capturing = (r_state == ST_RUN) || (r_state == ST_POST);
    assign w_capture   = wr_en && (wr_addr != '0) && filt_mask[wr_addr] && w_capturing;
    assign w_trigger   = trig_en && w_capture && (wr_addr == trig_addr) &&
                         ((wr_data & trig_mask) == (trig_val & trig_mask));

    assign w_push     = w_capture && !flush;
    assign w_pop      = out_ready && !w_empty && !flush;
    assign w_drop     = w_push && w_full && !w_pop;
    assign w_wr_entry = {r_ts, wr_addr, wr_data};

    trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_clear (flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_wr_entry),
        .o_data  (w_rd_entry),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop_cnt <= '0;
        end else if (flush) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + DROP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_OFF;
            r_post_cnt <= '0;
        end else if (flush) begin
            r_state    <= ST_OFF;
            r_post_cnt <= '0;
        end else begin
            case (r_state)
                ST_OFF, ST_HALT: begin
                    if (arm) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_trigger) begin
                        r_post_cnt <= POST_LD;
                        r_state    <= (POST_N == 0) ? ST_HALT : ST_POST;
                    end
                end
                ST_POST: begin
                    // Every attempt counts, whether or not the FIFO had room.
                    if (w_capture) begin
                        r_post_cnt <= r_post_cnt - PC_W'(1);
                        if (r_post_cnt == PC_W'(1)) r_state <= ST_HALT;
                    end
                end
                default: r_state <= ST_OFF;
            endcase
        end
    end

    assign out_valid = !w_empty;
    assign out_ts    = w_rd_entry[ENTRY_W-1 -: TS_W];
    assign out_addr  = w_rd_entry[DATA_W +: ADDR_W];
    assign out_data  = w_rd_entry[DATA_W-1:0];
    assign drop_cnt  = r_drop_cnt;
    assign state     = r_state;

endmodule

// File: tb/tb_reg_trace_buffer.sv
// Self-checking bench for reg_trace_buffer: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_reg_trace_buffer;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 16;
    localparam int TS_W   = 16;
    localparam int POST_N = 4;
    localparam int EW     = TS_W + ADDR_W + DATA_W;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   wr_en = 1'b0;
    logic [ADDR_W-1:0]      wr_addr = '0;
    logic [DATA_W-1:0]      wr_data = '0;
    logic [(1<<ADDR_W)-1:0] filt_mask = '0;
    logic                   arm = 1'b0;
    logic                   flush = 1'b0;
    logic                   trig_en = 1'b0;
    logic [ADDR_W-1:0]      trig_addr = '0;
    logic [DATA_W-1:0]      trig_val = '0;
    logic [DATA_W-1:0]      trig_mask = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [TS_W-1:0]        out_ts;
    logic [ADDR_W-1:0]      out_addr;
    logic [DATA_W-1:0]      out_data;
    logic [$clog2(DEPTH):0] count;
    logic [15:0]            drop_cnt;
    logic [1:0]             state;

    always #5 clk = ~clk;

    reg_trace_buffer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .TS_W   (TS_W),
        .POST_N (POST_N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .filt_mask (filt_mask),
        .arm       (arm),
        .flush     (flush),
        .trig_en   (trig_en),
        .trig_addr (trig_addr),
        .trig_val  (trig_val),
        .trig_mask (trig_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ts    (out_ts),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .count     (count),
        .drop_cnt  (drop_cnt),
        .state     (state)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: entries in arrival order, state as 0..3.
    logic [EW-1:0]   m_q[$];
    int              m_state;
    int              m_post;
    int              m_drop;
    logic [TS_W-1:0] m_ts;

    task automatic model_reset();
        m_q.delete();
        m_state = 0;
        m_post  = 0;
        m_drop  = 0;
        m_ts    = '0;
    endtask

    task automatic model_step();
        bit cap;
        bit hit;
        cap = wr_en && (wr_addr != 0) && filt_mask[wr_addr] && (m_state == 1 || m_state == 2);
        hit = trig_en && (wr_addr == trig_addr) && ((wr_data & trig_mask) == (trig_val & trig_mask));
        if (flush) begin
            m_q.delete();
            m_drop  = 0;
            m_state = 0;
            m_post  = 0;
        end else begin
            if (out_ready && m_q.size() != 0) void'(m_q.pop_front());
            if (cap) begin
                if (m_q.size() < DEPTH) m_q.push_back({m_ts, wr_addr, wr_data});
                else if (m_drop < 65535) m_drop = m_drop + 1;
            end
            if (m_state == 0 || m_state == 3) begin
                if (arm) m_state = 1;
            end else if (m_state == 1) begin
                if (cap && hit) begin
                    if (POST_N == 0) m_state = 3;
                    else begin
                        m_state = 2;
                        m_post  = POST_N;
                    end
                end
            end else if (cap) begin
                m_post = m_post - 1;
                if (m_post == 0) m_state = 3;
            end
        end
        m_ts = m_ts + 1'b1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        wr_en = 1'b0;
        arm   = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        model_reset();
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
        n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
        n_cmp++; if ({out_ts, out_addr, out_data} !== '0) begin n_bad++; $display("FAIL reset_outs: got ts=%h a=%h d=%h want 0", out_ts, out_addr, out_data); end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_basic_capture();
        filt_mask = '1;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
        tick();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234_5678;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_no_fallthrough: got %b want 0", out_valid); end
        tick();
        wr_en = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_addr !== 5'd5) begin n_bad++; $display("FAIL basic_addr: got %0d want 5", out_addr); end
        n_cmp++; if (out_data !== 32'h1234_5678) begin n_bad++; $display("FAIL basic_data: got %h want 12345678", out_data); end
        n_cmp++; if (out_ts !== 16'd3) begin n_bad++; $display("FAIL basic_ts: got %0d want 3", out_ts); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL basic_pop_count: got %0d want 0", count); end
    endtask

    task automatic test_filter();
        filt_mask = ~(32'h80);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = $urandom;
        tick();
        wr_addr = 5'd7; wr_data = $urandom;
        tick();
        wr_en = 1'b0;
        n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL filter_count: got %0d want 0", count); end
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL filter_state: got %0d want 1", state); end
    endtask

    task automatic test_full_drop();
        logic [EW-1:0] h;
        filt_mask = '1;
        out_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            wr_en = 1'b1; wr_addr = ADDR_W'($urandom_range(1, 31)); wr_data = $urandom;
            tick();
        end
        wr_en = 1'b0;
        h = m_q[0];
        n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL full_count: got %0d want 16", count); end
        n_cmp++; if (drop_cnt !== 16'd2) begin n_bad++; $display("FAIL full_drop: got %0d want 2", drop_cnt); end
        n_cmp++; if ({out_ts, out_addr, out_data} !== h) begin n_bad++; $display("FAIL full_head: got %h want %h", {out_ts, out_addr, out_data}, h); end
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = $urandom; out_ready = 1'b1;
        tick();
        wr_en = 1'b0; out_ready = 1'b0;
        h = m_q[0];
        n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL pushpop_count: got %0d want 16", count); end
        n_cmp++; if (drop_cnt !== 16'd2) begin n_bad++; $display("FAIL pushpop_drop: got %0d want 2", drop_cnt); end
        n_cmp++; if ({out_ts, out_addr, out_data} !== h) begin n_bad++; $display("FAIL pushpop_head: got %h want %h", {out_ts, out_addr, out_data}, h); end
    endtask

    task automatic test_flush();
        flush = 1'b1; arm = 1'b1; wr_en = 1'b1; wr_addr = 5'd4; wr_data = $urandom; out_ready = 1'b1;
        tick();
        set_idle();
        out_ready = 1'b0;
        n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL flush_count: got %0d want 0", count); end
        n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL flush_drop: got %0d want 0", drop_cnt); end
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL flush_state: got %0d want 0", state); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_trigger();
        trig_en = 1'b1; trig_addr = 5'd2; trig_val = 32'hFF; trig_mask = 32'hFF;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        filt_mask = ~(32'h4);
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h1FF;
        tick();
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL trig_filtered_state: got %0d want 1", state); end
        filt_mask = '1;
        tick();
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL trig_post_state: got %0d want 2", state); end
        n_cmp++; if (count !== 5'd1) begin n_bad++; $display("FAIL trig_captured: got %0d want 1", count); end
        for (int i = 0; i < 4; i++) begin
            wr_addr = 5'd3; wr_data = $urandom;
            tick();
            if (i == 2) begin
                n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL trig_still_post: got %0d want 2", state); end
            end
        end
        n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL trig_halt_state: got %0d want 3", state); end
        for (int i = 0; i < 3; i++) begin
            wr_addr = 5'd6; wr_data = $urandom;
            tick();
        end
        wr_en = 1'b0;
        n_cmp++; if (count !== 5'd5) begin n_bad++; $display("FAIL trig_halt_count: got %0d want 5", count); end
        n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL trig_halt_hold: got %0d want 3", state); end
    endtask

    task automatic test_reset_mid();
        flush = 1'b1;
        tick();
        flush = 1'b0; arm = 1'b1;
        tick();
        arm = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h0FF;
        tick();
        for (int i = 0; i < 2; i++) begin
            wr_addr = 5'd9; wr_data = $urandom;
            tick();
        end
        wr_en = 1'b0;
        n_cmp++; if (count !== 5'd3 || state !== 2'd2) begin n_bad++; $display("FAIL midrst_setup: got count=%0d state=%0d want 3/2", count, state); end
        out_ready = 1'b1;
        reset = 1'b0;
        #2;
        model_reset();
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL midrst_state: got %0d want 0", state); end
        n_cmp++; if (count !== '0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_count: got %0d/%b want 0/0", count, out_valid); end
        n_cmp++; if ({out_ts, out_addr, out_data} !== '0) begin n_bad++; $display("FAIL midrst_outs: got ts=%h a=%h d=%h want 0", out_ts, out_addr, out_data); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        out_ready = 1'b0;
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL midrst_arm_state: got %0d want 1", state); end
        n_cmp++; if (count !== '0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_arm_empty: got %0d/%b want 0/0", count, out_valid); end
    endtask

    task automatic test_random();
        logic [EW-1:0] h;
        trig_en = 1'b1; trig_mask = 32'hF;
        for (int c = 0; c < 600; c++) begin
            if (c % 100 == 0) begin
                filt_mask = $urandom | 32'h0000_0F00;
                trig_addr = ADDR_W'($urandom_range(8, 11));
                trig_val  = $urandom;
            end
            wr_en   = ($urandom_range(0, 3) != 0);
            wr_addr = ($urandom_range(0, 1) == 0) ? trig_addr : ADDR_W'($urandom_range(0, 31));
            wr_data = $urandom;
            arm     = ($urandom_range(0, 15) == 0);
            flush   = ($urandom_range(0, 79) == 0);
            out_ready = (c % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
            tick();
            h = (m_q.size() != 0) ? m_q[0] : '0;
            n_cmp++; if (state !== 2'(m_state)) begin n_bad++; $display("FAIL rand_state c=%0d: got %0d want %0d", c, state, m_state); end
            n_cmp++; if (count !== 5'(m_q.size())) begin n_bad++; $display("FAIL rand_count c=%0d: got %0d want %0d", c, count, m_q.size()); end
            n_cmp++; if (out_valid !== (m_q.size() != 0)) begin n_bad++; $display("FAIL rand_valid c=%0d: got %b want %b", c, out_valid, m_q.size() != 0); end
            n_cmp++; if (drop_cnt !== 16'(m_drop)) begin n_bad++; $display("FAIL rand_drop c=%0d: got %0d want %0d", c, drop_cnt, m_drop); end
            n_cmp++; if ({out_ts, out_addr, out_data} !== h) begin n_bad++; $display("FAIL rand_head c=%0d: got %h want %h", c, {out_ts, out_addr, out_data}, h); end
        end
        set_idle();
        out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic_capture();
        test_filter();
        test_full_drop();
        test_flush();
        test_trigger();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
